// File: rtl/fetch_stage_if.sv
// Fetch-to-decode pipeline register bundle: instruction word plus next-PC.
// Latency: none; carries registered state owned by the fetch stage.
// Backpressure: none; the fetch stage's en input gates every update.
//
// Signals
//   instruction  [31:0]  instruction handed to decode (0 = bubble)
//   instr_npc    [31:0]  address of that instruction + 4 (0 for a bubble)
interface fetch_decode_if;
  logic [31:0] instruction;
  logic [31:0] instr_npc;

  modport fetch (
    output instruction,
    output instr_npc
  );

  modport decode (
    input instruction,
    input instr_npc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests imem, loads the fetch/decode register.
// Latency: a word hit in cycle N is on out after the N edge when en=1; out is fully registered.
// Backpressure: en=0 holds out and PC; with FETCH_SKID_EN a word hit under stall is parked, otherwise it is refetched.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   en                pipeline advance; out and PC move only when 1 (redirects excepted)
//   ihit, imemload    imem response: imemload valid for imemaddr when ihit=1
//   imemREN, imemaddr imem request; imemaddr is always the PC
//   jump_instr, branch_target  redirect from decode
//   ex_taken, ex_target        redirect from execute (wins over decode)
//   out               fetch_decode_if.fetch: instruction, instr_npc
//   halted            fetch has stopped after handing a HALT opcode to decode
//
// Build option: define FETCH_SKID_EN to add a one-entry skid buffer and the HOLD state.
module fetch_stage #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        jump_instr,
  input  logic [31:0] branch_target,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  fetch_decode_if.fetch out,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] npc_q, npc_n;

  logic        redirect;
  logic [31:0] redirect_pc;

  // Word candidate for this edge: live imem data in FETCH, parked data in HOLD.
  logic        word_vld;
  logic [31:0] word_dat;
  logic [31:0] word_pc;

`ifdef FETCH_SKID_EN
  logic [31:0] skid_word;
  logic [31:0] skid_pc;
  logic        skid_load;
`endif

  // Execute resolves an older instruction than decode, so its redirect wins.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = pc;
    if (ex_taken) begin
      redirect    = 1'b1;
      redirect_pc = ex_target;
    end else if (jump_instr) begin
      redirect    = 1'b1;
      redirect_pc = branch_target;
    end
  end

  always_comb begin
    word_vld = (state == FETCH) && ihit;
    word_dat = imemload;
    word_pc  = pc;
`ifdef FETCH_SKID_EN
    if (state == HOLD) begin
      word_vld = 1'b1;
      word_dat = skid_word;
      word_pc  = skid_pc;
    end
`endif
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr_q;
    npc_n   = npc_q;
`ifdef FETCH_SKID_EN
    skid_load = 1'b0;
`endif
    if (redirect) begin
      // Redirect always lands, even under stall; any fetched or parked word is
      // on the wrong path and is dropped by returning to FETCH.
      pc_n    = redirect_pc;
      state_n = FETCH;
      if (en) begin
        instr_n = 32'd0;
        npc_n   = 32'd0;
      end
    end else if (en) begin
      if (word_vld) begin
        instr_n = word_dat;
        npc_n   = word_pc + 32'd4;
        pc_n    = word_pc + 32'd4;
        state_n = (word_dat[31:26] == HALT_OPCODE) ? HALTED : FETCH;
      end else begin
        // Nothing to hand over (miss, or halted): insert a bubble.
        instr_n = 32'd0;
        npc_n   = 32'd0;
      end
    end else begin
`ifdef FETCH_SKID_EN
      if ((state == FETCH) && ihit) begin
        skid_load = 1'b1;
        state_n   = HOLD;
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= FETCH;
      pc      <= PC_INIT;
      instr_q <= 32'd0;
      npc_q   <= 32'd0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      instr_q <= instr_n;
      npc_q   <= npc_n;
    end
  end

`ifdef FETCH_SKID_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      skid_word <= 32'd0;
      skid_pc   <= 32'd0;
    end else if (skid_load) begin
      skid_word <= imemload;
      skid_pc   <= pc;
    end
  end
`endif

  assign imemREN         = (state == FETCH);
  assign imemaddr        = pc;
  assign halted          = (state == HALTED);
  assign out.instruction = instr_q;
  assign out.instr_npc   = npc_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam logic [31:0] PC_INIT = 32'h0000_0100;

  logic        CLK;
  logic        RST;
  logic        en;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        jump_instr;
  logic [31:0] branch_target;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        halted;

  fetch_decode_if fd();

  fetch_stage #(.PC_INIT(PC_INIT), .HALT_OPCODE(6'h3F)) dut (
    .CLK(CLK), .RST(RST), .en(en), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .jump_instr(jump_instr), .branch_target(branch_target),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .out(fd), .halted(halted)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Behavioural reference: what decode should see, derived from the fetch rules.
  logic [31:0] m_pc, m_instr, m_npc, m_skid_word;
  logic        m_halted, m_skid;

  task automatic model_reset();
    m_pc = PC_INIT; m_instr = 0; m_npc = 0; m_halted = 0; m_skid = 0; m_skid_word = 0;
  endtask

  task automatic model_edge(input logic e, input logic h, input logic [31:0] w,
                            input logic j, input logic [31:0] bt,
                            input logic x, input logic [31:0] xt);
    logic [31:0] word;
    if (x || j) begin
      m_pc = x ? xt : bt;
      m_halted = 0;
      m_skid = 0;
      if (e) begin m_instr = 0; m_npc = 0; end
    end else if (e) begin
      if (!m_halted && (m_skid || h)) begin
        word = m_skid ? m_skid_word : w;
        m_instr = word;
        m_npc = m_pc + 4;
        m_pc = m_pc + 4;
        m_skid = 0;
        if (word[31:26] == 6'h3F) m_halted = 1;
      end else begin
        m_instr = 0; m_npc = 0;
      end
    end else begin
`ifdef FETCH_SKID_EN
      if (!m_halted && !m_skid && h) begin
        m_skid = 1;
        m_skid_word = w;
      end
`endif
    end
  endtask

  // One clock: drive after the falling edge, let the rising edge happen, settle 1ns.
  task automatic tick(input logic e, input logic h, input logic [31:0] w,
                      input logic j, input logic [31:0] bt,
                      input logic x, input logic [31:0] xt);
    @(negedge CLK);
    en = e; ihit = h; imemload = h ? w : 32'hDEAD_BEEF;
    jump_instr = j; branch_target = bt; ex_taken = x; ex_target = xt;
    @(posedge CLK);
    model_edge(e, h, imemload, j, bt, x, xt);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; ihit = 0; imemload = 0; jump_instr = 0; branch_target = 0; ex_taken = 0; ex_target = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    RST = 1;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (imemaddr !== PC_INIT) begin errors++; $display("FAIL reset_addr: got %h expected %h", imemaddr, PC_INIT); end
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL reset_ren: got %b expected 1", imemREN); end
    checks++; if (fd.instruction !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", fd.instruction); end
    checks++; if (fd.instr_npc !== 32'd0) begin errors++; $display("FAIL reset_npc: got %h expected 0", fd.instr_npc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h2401_000A; words[1] = 32'h2402_0005; words[2] = 32'h0022_1821;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imemaddr !== PC_INIT + 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imemaddr, PC_INIT + 32'(4 * i)); end
      tick(1, 1, words[i], 0, 0, 0, 0);
      checks++;
      if (fd.instruction !== words[i]) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, fd.instruction, words[i]); end
      checks++;
      if (fd.instr_npc !== PC_INIT + 32'(4 * i + 4)) begin errors++; $display("FAIL seq_npc[%0d]: got %h expected %h", i, fd.instr_npc, PC_INIT + 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_miss_bubbles();
    tick(0, 0, 0, 1, 32'h40, 0, 0);
    checks++; if (fd.instruction !== 32'h0022_1821) begin errors++; $display("FAIL miss_stall_hold: got %h expected 00221821", fd.instruction); end
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, 0, 0, 0, 0);
      checks++; if (fd.instruction !== 32'd0) begin errors++; $display("FAIL miss_bubble[%0d]: got %h expected 0", i, fd.instruction); end
      checks++; if (imemaddr !== 32'h40) begin errors++; $display("FAIL miss_pc[%0d]: got %h expected 40", i, imemaddr); end
    end
    tick(1, 1, 32'h1234_5678, 0, 0, 0, 0);
    checks++; if (fd.instr_npc !== 32'h44) begin errors++; $display("FAIL miss_resume_npc: got %h expected 44", fd.instr_npc); end
  endtask

  task automatic test_pc_wrap();
    tick(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    tick(1, 1, 32'h0000_0001, 0, 0, 0, 0);
    checks++; if (fd.instr_npc !== 32'd0) begin errors++; $display("FAIL wrap_npc: got %h expected 0", fd.instr_npc); end
    checks++; if (imemaddr !== 32'd0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", imemaddr); end
  endtask

  task automatic test_redirect_priority();
    tick(1, 1, 32'h1111_1111, 1, 32'h200, 1, 32'h80);
    checks++; if (imemaddr !== 32'h80) begin errors++; $display("FAIL prio_pc: got %h expected 80", imemaddr); end
    checks++; if (fd.instruction !== 32'd0) begin errors++; $display("FAIL prio_bubble: got %h expected 0", fd.instruction); end
  endtask

  task automatic test_halt();
    tick(0, 0, 0, 1, 32'h20, 0, 0);
    tick(1, 1, 32'hFC00_0000, 0, 0, 0, 0);
    checks++; if (fd.instruction !== 32'hFC00_0000) begin errors++; $display("FAIL halt_instr: got %h expected fc000000", fd.instruction); end
    checks++; if (fd.instr_npc !== 32'h24) begin errors++; $display("FAIL halt_npc: got %h expected 24", fd.instr_npc); end
    tick(1, 1, 32'h2222_2222, 0, 0, 0, 0);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL halt_ren: got %b expected 0", imemREN); end
    checks++; if (fd.instruction !== 32'd0) begin errors++; $display("FAIL halt_bubble: got %h expected 0", fd.instruction); end
    checks++; if (imemaddr !== 32'h24) begin errors++; $display("FAIL halt_pc: got %h expected 24", imemaddr); end
    tick(1, 0, 0, 0, 0, 1, 32'h30);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL unhalt_flag: got %b expected 0", halted); end
    checks++; if (imemaddr !== 32'h30) begin errors++; $display("FAIL unhalt_pc: got %h expected 30", imemaddr); end
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL unhalt_ren: got %b expected 1", imemREN); end
  endtask

  task automatic test_stall_hit();
    tick(0, 1, 32'h8C43_0000, 0, 0, 0, 0);
`ifdef FETCH_SKID_EN
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL skid_ren: got %b expected 0", imemREN); end
`else
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL noskid_ren: got %b expected 1", imemREN); end
`endif
    tick(1, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_SKID_EN
    checks++; if (fd.instruction !== 32'h8C43_0000) begin errors++; $display("FAIL skid_instr: got %h expected 8c430000", fd.instruction); end
    checks++; if (fd.instr_npc !== 32'h34) begin errors++; $display("FAIL skid_npc: got %h expected 34", fd.instr_npc); end
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL skid_refetch: got %b expected 1", imemREN); end
`else
    checks++; if (fd.instruction !== 32'd0) begin errors++; $display("FAIL noskid_drop: got %h expected 0", fd.instruction); end
    checks++; if (imemaddr !== 32'h30) begin errors++; $display("FAIL noskid_pc: got %h expected 30", imemaddr); end
`endif
  endtask

  task automatic test_async_reset();
    tick(0, 0, 0, 1, 32'h60, 0, 0);
    tick(1, 1, 32'hFC00_0001, 0, 0, 0, 0);
    @(posedge CLK);
    #3;
    RST = 1;
    model_reset();
    #1;
    checks++; if (halted !== 1'b0 || imemREN !== 1'b1) begin errors++; $display("FAIL arst_halted: halted %b ren %b expected 0 1", halted, imemREN); end
    checks++; if (fd.instruction !== 32'd0 || fd.instr_npc !== 32'd0) begin errors++; $display("FAIL arst_out: got %h %h expected 0 0", fd.instruction, fd.instr_npc); end
    checks++; if (imemaddr !== PC_INIT) begin errors++; $display("FAIL arst_pc: got %h expected %h", imemaddr, PC_INIT); end
    @(negedge CLK);
    RST = 0;
`ifdef FETCH_SKID_EN
    tick(0, 1, 32'h1357_9BDF, 0, 0, 0, 0);
    #2;
    RST = 1;
    model_reset();
    #1;
    checks++; if (imemREN !== 1'b1 || imemaddr !== PC_INIT) begin errors++; $display("FAIL arst_hold: ren %b addr %h expected 1 %h", imemREN, imemaddr, PC_INIT); end
    @(negedge CLK);
    RST = 0;
`endif
  endtask

  task automatic test_random();
    logic e, h, j, x;
    logic [31:0] w, bt, xt;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      e = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 9) < 7);
      x = ($urandom_range(0, 19) == 0);
      j = ($urandom_range(0, 13) == 0);
      w = $urandom();
      if ($urandom_range(0, 24) == 0) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31:26] = 6'h01;
      bt = $urandom() & 32'hFFFF_FFFC;
      xt = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) xt = 32'hFFFF_FFF8;
      tick(e, h, w, j, bt, x, xt);
      checks++; if (fd.instruction !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got %h expected %h", c, fd.instruction, m_instr); end
      checks++; if (fd.instr_npc !== m_npc) begin errors++; $display("FAIL rnd_npc[%0d]: got %h expected %h", c, fd.instr_npc, m_npc); end
      checks++; if (imemaddr !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", c, imemaddr, m_pc); end
      checks++; if (imemREN !== (!m_halted && !m_skid)) begin errors++; $display("FAIL rnd_ren[%0d]: got %b expected %b", c, imemREN, !m_halted && !m_skid); end
      checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted[%0d]: got %b expected %b", c, halted, m_halted); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_miss_bubbles();
    test_pc_wrap();
    test_redirect_priority();
    test_halt();
    test_stall_hit();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
